fmul_issue_ctrl: RTL and testbench
==================================

// Module: fmul_issue_ctrl
// PURPOSE
//  Shares one FP multiplier pipeline (fmul_s1 -> fmul_s2 -> fmul_s3) among NUM_REQ requesters.
//  - Round-robin arbitration: one operand pair is issued per cycle.
//  - Tracks the valid bit and requester ID of every stage, and drives the stage enables.
//  - Applies global backpressure from the result consumer and supports a synchronous flush.
//  - Control only: operand/result data paths are muxed outside using op_sel_o and res_id_o.
// PARAMETERS
//  NUM_REQ   4                        number of requesters (>=2)
//  ID_W      $clog2(NUM_REQ)          width of requester ID
//  LAT       3                        multiplier pipeline depth in stages (>=1)
//  CNT_W     $clog2(LAT+1)            width of occupancy count
// PORTS
//  clk_i         in   1            clock
//  rst_i         in   1            synchronous, active-high reset
//  req_valid_i   in   NUM_REQ      requester i has an operand pair ready
//  req_rm_i      in   3*NUM_REQ    rounding mode per requester, slice [3i+2:3i]
//  req_ready_o   out  NUM_REQ      one-hot; requester i's operands accepted this cycle
//  flush_i       in   1            drop all in-flight ops and block issue this cycle
//  issue_o       out  1            an op enters stage 0 this cycle
//  op_sel_o      out  ID_W         granted requester, for the operand mux (valid when issue_o)
//  rm_o          out  3            rm of granted requester, pipelined alongside its op
//  stage_en_o    out  LAT          per-stage register enable for the multiplier pipeline
//  res_valid_o   out  1            last stage holds a result
//  res_ready_i   in   1            consumer accepts the result
//  res_id_o      out  ID_W         requester that owns the result on the output
//  res_rm_o      out  3            rm carried with the result (to fmul_s3 in_rm_i)
//  occ_o         out  CNT_W        number of valid stages
//  idle_o        out  1            occ_o==0 and no req_valid_i asserted
// BEHAVIOUR
//  State per stage k: v[k], id[k], rm[k]. res_valid_o=v[LAT-1], res_id_o=id[LAT-1], res_rm_o=rm[LAT-1].
//  Reset (rst_i=1):
//  - v, id, rm, RR pointer ptr, and occ_o all go to 0.
//  - Every output is 0 except idle_o, which follows the req_valid_i-only term (0 if any req_valid_i, else 1).
//  - Reset mid-operation discards all in-flight ops; no result is emitted for them.
//  adv = ~v[LAT-1] | res_ready_i. The pipeline moves as a unit and never creates internal bubbles.
//  Arbitration (combinational):
//  - Pick the first i with req_valid_i[i], scanning ptr, ptr+1, ... mod NUM_REQ.
//  - grant = adv & ~flush_i & |req_valid_i.
//  - req_ready_o = onehot(i) when grant is 1, else 0. issue_o = grant. op_sel_o = i.
//  - rm_o = req_rm_i[3i+:3]. When issue_o=0, op_sel_o and rm_o are don't-care; the RTL drives 0.
//  Pointer: on grant, ptr <= (i==NUM_REQ-1) ? 0 : i+1. Otherwise ptr holds.
//  Pipeline update at the clock edge:
//  - if flush_i: v <= 0 (id/rm hold).
//  - else if adv: v[0] <= grant, id[0] <= i, rm[0] <= rm_o; v[k] <= v[k-1], id[k] <= id[k-1], rm[k] <= rm[k-1].
//  - else: all hold.
//  stage_en_o[0] = adv & grant; stage_en_o[k] = adv & v[k-1] for k>=1; all 0 on flush_i.
//  Latency: issue at edge t gives res_valid_o=1 in cycle t+LAT (LAT=3 -> 3 cycles).
//  - Back-to-back issues give one result per cycle while res_ready_i=1.
//  Stall: res_valid_o=1 and res_ready_i=0 gives adv=0.
//  - All stages hold; req_ready_o=0.
//  - res_id_o and res_rm_o are stable until accepted.
//  Simultaneous events:
//  - Result pop and new issue in the same cycle are allowed (adv=1).
//  - flush_i overrides both grant and res_ready_i; the result is dropped, not consumed.
//  - Requesters deasserting req_valid_i without ready never corrupt ptr.
//  occ_o = popcount(v). It saturates naturally at LAT.
//  The pipeline is full when occ_o==LAT and issue still proceeds if adv=1.
//  Single requester: it is granted every cycle and ptr wraps NUM_REQ-1 -> 0 correctly.
// TESTING
//  1 Reset: assert rst_i 2 cycles while requests are pending -> all outputs 0, ptr=0; first grant after release goes to req 0.
//  2 RR fairness: req_valid_i=4'b1111 steady, res_ready_i=1 -> grants 0,1,2,3,0,...; res_id_o sequence identical, delayed 3 cycles.
//  3 Skip/wrap: ptr=3, req_valid_i=4'b0101 -> grant 0, then 2, then 0; ptr values 1,3,1.
//  4 Backpressure: fill 3 ops (ids 1,2,3), hold res_ready_i=0 for 5 cycles -> req_ready_o=0, res_id_o=1 stable, occ_o=3; release -> ids 1,2,3 pop on consecutive cycles.
//  5 Flush: 2 ops in flight plus req_valid_i=4'b0010 with flush_i=1 -> req_ready_o=0, next cycle occ_o=0, no res_valid_o for them.
//  6 Pop+issue: res_valid_o=1 with res_ready_i=1 and req 2 valid -> same-cycle grant; occ_o stays constant; rm 3'b011 of req 2 appears on res_rm_o 3 cycles later.

Source files
------------

// File: rtl/fmul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// fmul_issue_ctrl : round-robin issue control for a shared LAT-stage FP multiplier
// Revision: 1.0
// ============================================================================
module fmul_issue_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int LAT     = 3,
  parameter int CNT_W   = $clog2(LAT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [3*NUM_REQ-1:0] req_rm_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic                 flush_i,
  output logic                 issue_o,
  output logic [ID_W-1:0]      op_sel_o,
  output logic [2:0]           rm_o,
  output logic [LAT-1:0]       stage_en_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [ID_W-1:0]      res_id_o,
  output logic [2:0]           res_rm_o,
  output logic [CNT_W-1:0]     occ_o,
  output logic                 idle_o
);

  logic [LAT-1:0]  v_q, v_d;
  logic [ID_W-1:0] id_q [LAT];
  logic [ID_W-1:0] id_d [LAT];
  logic [2:0]      rm_q [LAT];
  logic [2:0]      rm_d [LAT];
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            any_req;
  logic            adv;
  logic            grant;
  logic [ID_W-1:0] sel;
  logic [2:0]      sel_rm;
  logic [CNT_W-1:0] occ;

  // Scan from the highest offset down so the entry closest to ptr wins.
  always_comb begin
    int idx;
    sel    = '0;
    sel_rm = 3'b000;
    idx    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid_i[ID_W'(idx)]) sel = ID_W'(idx);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == ID_W'(i)) sel_rm = req_rm_i[3*i +: 3];
    end
  end

  assign any_req = |req_valid_i;
  assign adv     = ~v_q[LAT-1] | res_ready_i;
  assign grant   = adv & ~flush_i & any_req & ~rst_i;

  always_comb begin
    req_ready_o = grant ? (NUM_REQ'(1) << sel) : '0;
    issue_o     = grant;
    op_sel_o    = grant ? sel : '0;
    rm_o        = grant ? sel_rm : 3'b000;
  end

  always_comb begin
    ptr_d = ptr_q;
    v_d   = v_q;
    for (int k = 0; k < LAT; k++) begin
      id_d[k] = id_q[k];
      rm_d[k] = rm_q[k];
    end
    if (grant) ptr_d = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
    if (flush_i) begin
      v_d = '0;
    end else if (adv) begin
      v_d[0]  = grant;
      id_d[0] = sel;
      rm_d[0] = rm_o;
      for (int k = 1; k < LAT; k++) begin
        v_d[k]  = v_q[k-1];
        id_d[k] = id_q[k-1];
        rm_d[k] = rm_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= '0;
      ptr_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        id_q[k] <= '0;
        rm_q[k] <= 3'b000;
      end
    end else begin
      v_q   <= v_d;
      ptr_q <= ptr_d;
      for (int k = 0; k < LAT; k++) begin
        id_q[k] <= id_d[k];
        rm_q[k] <= rm_d[k];
      end
    end
  end

  always_comb begin
    stage_en_o    = '0;
    stage_en_o[0] = adv & grant;
    for (int k = 1; k < LAT; k++) begin
      stage_en_o[k] = adv & v_q[k-1] & ~flush_i & ~rst_i;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < LAT; k++) occ = occ + CNT_W'(v_q[k]);
  end

  // Outputs are forced low while reset is held, before the flops have cleared.
  assign res_valid_o = v_q[LAT-1] & ~rst_i;
  assign res_id_o    = rst_i ? '0 : id_q[LAT-1];
  assign res_rm_o    = rst_i ? 3'b000 : rm_q[LAT-1];
  assign occ_o       = rst_i ? '0 : occ;
  assign idle_o      = ~any_req & (rst_i | (occ == '0));

endmodule
`default_nettype wire

// File: tb/tb_fmul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fmul_issue_ctrl : randomized + directed bench with a queue-based reference model
// Revision: 1.0
// ============================================================================
module tb_fmul_issue_ctrl;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 3;
  localparam int CNT_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [3*NUM_REQ-1:0] req_rm = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 flush = 1'b0;
  logic                 issue;
  logic [ID_W-1:0]      op_sel;
  logic [2:0]           rm_out;
  logic [LAT-1:0]       stage_en;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic [ID_W-1:0]      res_id;
  logic [2:0]           res_rm;
  logic [CNT_W-1:0]     occ;
  logic                 idle;

  int n_cmp = 0;
  int n_err = 0;

  fmul_issue_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_rm_i(req_rm),
    .req_ready_o(req_ready), .flush_i(flush), .issue_o(issue), .op_sel_o(op_sel),
    .rm_o(rm_out), .stage_en_o(stage_en), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_id_o(res_id), .res_rm_o(res_rm), .occ_o(occ), .idle_o(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ptr plus a queue of LAT slots, slot 0 = newest op.
  typedef struct { bit v; int id; int rm; } slot_t;
  slot_t pipe[$];
  int    m_ptr = 0;

  initial for (int k = 0; k < LAT; k++) pipe.push_back('{0, 0, 0});

  function automatic int winner();
    for (int off = 0; off < NUM_REQ; off++)
      if (req_valid[(m_ptr + off) % NUM_REQ]) return (m_ptr + off) % NUM_REQ;
    return -1;
  endfunction

  function automatic bit m_adv();
    return !pipe[LAT-1].v || res_ready;
  endfunction

  function automatic bit m_grant();
    return m_adv() && !flush && (req_valid != 0) && !rst;
  endfunction

  function automatic int m_occ();
    int n = 0;
    foreach (pipe[k]) if (pipe[k].v) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    bit g;
    int w;
    logic [LAT-1:0] en;
    g = m_grant();
    w = winner();
    chk("issue", issue, g);
    chk("req_ready", req_ready, g ? (32'd1 << w) : 32'd0);
    chk("op_sel", op_sel, g ? w : 0);
    chk("rm_o", rm_out, g ? (req_rm >> (3 * w)) & 7 : 0);
    chk("res_valid", res_valid, !rst && pipe[LAT-1].v);
    if (rst) begin
      chk("res_id_rst", res_id, 0);
      chk("res_rm_rst", res_rm, 0);
    end else if (pipe[LAT-1].v) begin
      chk("res_id", res_id, pipe[LAT-1].id);
      chk("res_rm", res_rm, pipe[LAT-1].rm);
    end
    chk("occ", occ, rst ? 0 : m_occ());
    chk("idle", idle, (req_valid == 0) && (rst || m_occ() == 0));
    en = '0;
    en[0] = g;
    for (int k = 1; k < LAT; k++) en[k] = m_adv() && pipe[k-1].v && !flush && !rst;
    chk("stage_en", stage_en, en);
  end

  always @(posedge clk) begin
    bit g;
    int w;
    g = m_grant();
    w = winner();
    if (rst) begin
      m_ptr = 0;
      foreach (pipe[k]) pipe[k] = '{0, 0, 0};
    end else begin
      if (g) m_ptr = (w + 1) % NUM_REQ;
      if (flush) begin
        foreach (pipe[k]) pipe[k].v = 0;
      end else if (m_adv()) begin
        void'(pipe.pop_back());
        pipe.push_front('{g, g ? w : 0, g ? int'((req_rm >> (3 * w)) & 7) : 0});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int ops[8];

  initial begin
    // rm per requester: 0->001, 1->010, 2->011, 3->100
    req_rm    = {3'b100, 3'b011, 3'b010, 3'b001};
    req_valid = 4'b1111;
    rst       = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("lit_rst_ready", req_ready, 0);
      chk("lit_rst_valid", res_valid, 0);
      cyc();
    end
    rst = 1'b0;
    // RR fairness with res_id trailing by LAT cycles
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ops[c] = int'(op_sel);
      chk("lit_rr_grant", op_sel, c % 4);
      if (c == 0) chk("lit_first_ready", req_ready, 4'b0001);
      if (c >= LAT) begin
        chk("lit_rr_res_valid", res_valid, 1);
        chk("lit_rr_res_id", res_id, ops[c - LAT]);
      end
      cyc();
    end
    req_valid = 4'b0000;
    repeat (4) cyc();
    // Skip/wrap: move ptr to 3, then grants 0,2,0
    req_valid = 4'b0100;
    cyc();
    req_valid = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lit_wrap_grant", op_sel, (c == 1) ? 2 : 0);
      cyc();
    end
    req_valid = 4'b0000;
    repeat (4) cyc();
    // Backpressure: ids 1,2,3 in flight, stall 5 cycles, then drain
    req_valid = 4'b1110;
    repeat (3) cyc();
    req_valid = 4'b1111;
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("lit_bp_ready", req_ready, 0);
      chk("lit_bp_id", res_id, 1);
      chk("lit_bp_occ", occ, 3);
      cyc();
    end
    req_valid = 4'b0000;
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lit_drain_valid", res_valid, 1);
      chk("lit_drain_id", res_id, c + 1);
      cyc();
    end
    // Flush with two ops in flight
    req_valid = 4'b0011;
    repeat (2) cyc();
    req_valid = 4'b0010;
    flush     = 1'b1;
    @(negedge clk);
    chk("lit_flush_ready", req_ready, 0);
    cyc();
    flush     = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("lit_flush_occ", occ, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("lit_flush_nores", res_valid, 0);
      cyc();
    end
    // Pop + issue in the same cycle, rm of req 2 follows to res_rm
    req_valid = 4'b0001;
    repeat (3) cyc();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("lit_pi_valid", res_valid, 1);
    chk("lit_pi_issue", op_sel, 2);
    chk("lit_pi_occ", occ, 3);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("lit_pi_occ2", occ, 3);
    cyc();
    cyc();
    @(negedge clk);
    chk("lit_pi_res_id", res_id, 2);
    chk("lit_pi_res_rm", res_rm, 3'b011);
    cyc();
    // Randomized traffic; the model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      req_valid = NUM_REQ'($urandom_range(0, 15));
      req_rm    = 12'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cyc();
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
